seek_command_generator: RTL and testbench
=========================================

// Module: seek_command_generator
// PURPOSE
//  Controller-side initiator of the 2310 access protocol; drives the arm that seek_to_cylinder emulates.
//  Converts an absolute target cylinder into a train of 1- or 2-cylinder ACC_GO steps, each paced by the drive's ACCESS_RDY handshake.
//  Tracks the arm position; recalibrates to home (cyl 0) on request. Used by the real-drive test path and the controller bench.
// PARAMETERS
//  MAX_CYL          202    highest legal cylinder
//  SETUP_US         2      REV/10_20 valid before GO asserted (usec)
//  GO_PULSE_US      4      ACC_GO low width (usec)
//  DROP_TIMEOUT_US  10000  max wait for ACCESS_RDY to fall after GO
//  RISE_TIMEOUT_US  30000  max wait for ACCESS_RDY to return high
//  MAX_RECAL_STEPS  110    reverse 2-cyl steps allowed before recal fails
// PORTS
//  clock               in   1  master clock, 40 MHz
//  reset_l             in   1  asynchronous reset, active low
//  clkenbl_1usec       in   1  1 usec clock enable from timing generator
//  seek_request        in   1  1-clock strobe: seek to target_cylinder
//  recal_request       in   1  1-clock strobe: step reverse until home
//  target_cylinder     in   8  absolute target, sampled on seek_request
//  BUS_ACCESS_RDY_H    in   1  drive ready, asynchronous
//  BUS_HOME_L          in   1  drive at cylinder 0 when low, asynchronous
//  BUS_ACC_GO_L        out  1  step strobe, low = go
//  BUS_ACC_REV_L       out  1  high = forward, low = reverse
//  BUS_10_20_L         out  1  high = 2-cyl step, low = 1-cyl step
//  current_cylinder    out  8  tracked arm position
//  seek_busy           out  1  high from accepted request until done/error
//  seek_done           out  1  1-clock pulse on successful completion
//  seek_error          out  1  sticky until next accepted request
// BEHAVIOUR
//  Reset (async, immediate): GO_L=1, REV_L=1, 10_20_L=1, current_cylinder=0, busy=0, done=0, error=0, state IDLE, timer=0.
//  BUS_ACCESS_RDY_H and BUS_HOME_L pass 3-flop synchronizers; all decisions use synchronized copies (3-clock latency).
//  States: IDLE -> SETUP -> PULSE -> WAIT_DROP -> WAIT_RISE -> (SETUP | DONE | ERROR) -> IDLE.
//  IDLE: recal_request wins over simultaneous seek_request; requests while busy ignored.
//   seek_request: target>MAX_CYL -> error=1, busy stays 0, no step; target==current -> done pulse next clock, no step; else busy=1, latch target, SETUP.
//   recal_request: busy=1, recal mode, step count=0; if home already low -> current=0, DONE.
//  SETUP: delta=target-current (9-bit signed); REV_L=(delta>0); 10_20_L=(|delta|>=2); recal: REV_L=0, 10_20_L=1. Hold SETUP_US usec.
//  PULSE: GO_L=0 for GO_PULSE_US usec, then GO_L=1; REV/10_20 held stable through WAIT_RISE.
//  WAIT_DROP: synced ready falling edge -> WAIT_RISE; timer reaches DROP_TIMEOUT_US -> ERROR.
//  WAIT_RISE: synced ready rising edge -> update current (+/-1 or 2, clamp 0..MAX_CYL); home low forces current=0.
//   seek: current==target -> DONE else SETUP. recal: home low -> DONE; step count==MAX_RECAL_STEPS -> ERROR; else SETUP.
//   Timeout at RISE_TIMEOUT_US -> ERROR, current unchanged.
//  DONE: seek_done=1 one clock, busy=0. ERROR: error=1, busy=0, GO_L=1.
//  Timer: 16-bit, cleared on state entry, increments on clkenbl_1usec only.
//  Home low seen on a forward step completion: current forced 0, seek continues from 0.
// STRUCTURE
//  Shared include seek_2310_defs.vh: state encodings, MAX_CYL, step sizes, bus polarity constants (shared with seek_to_cylinder).
//  Sub-module: bus_input_sync (3-flop synchronizer + edge detect), instantiated for ready and home.
//  Remainder in one always block: FSM, usec timer, position tracker.
// TESTING
//  Bench pairs DUT with seek_to_cylinder (virtual mode) as responder, plus a scripted drive model for faults.
//  Seek 0->7: steps +2,+2,+2,+1; REV_L=1; current=7; one done pulse; 4 GO pulses each >=4 usec.
//  Seek 100->97: steps -2,-1 with REV_L=0; current=97; responder cylinder matches 97.
//  target=203: seek_error=1 same cycle+1, no GO pulse, busy never asserted; next valid request clears error.
//  Recal from 9 (model asserts home after 5th step): 5 reverse 2-cyl steps, current=0, done.
//  Ready never drops: ERROR after 10000 usec, GO_L=1; reset_l low mid-PULSE -> GO_L=1 asynchronously, current=0.
//  seek_request+recal_request same clock at cyl 50: recal executed, seek ignored, current=0.

Source files
------------

// File: rtl/seek_command_generator_pkg.sv
// Shared constants for the 2310 access-protocol initiator: FSM encodings,
// cylinder limits, usec timing limits, bus polarities and the arm-position
// stepping helper.
package seek_command_generator_pkg;

  // Highest legal cylinder on the 2310.
  localparam logic [7:0]  MAX_CYL         = 8'd202;

  // Timing, in 1 usec ticks of clkenbl_1usec.
  localparam logic [15:0] SETUP_US        = 16'd2;
  localparam logic [15:0] GO_PULSE_US     = 16'd4;
  localparam logic [15:0] DROP_TIMEOUT_US = 16'd10000;
  localparam logic [15:0] RISE_TIMEOUT_US = 16'd30000;

  // Reverse steps allowed before a recalibrate gives up.
  localparam logic [6:0]  MAX_RECAL_STEPS = 7'd110;

  // Step sizes selected by BUS_10_20_L.
  localparam logic [8:0]  STEP_ONE_CYL    = 9'd1;
  localparam logic [8:0]  STEP_TWO_CYL    = 9'd2;

  // Bus polarities (all bus outputs are active low).
  localparam logic        GO_ASSERT       = 1'b0;
  localparam logic        GO_IDLE         = 1'b1;
  localparam logic        REV_FWD         = 1'b1;
  localparam logic        REV_REV         = 1'b0;
  localparam logic        STEP_TWO        = 1'b1;
  localparam logic        STEP_ONE        = 1'b0;

  // FSM state encodings.
  localparam logic [2:0]  ST_IDLE         = 3'd0;
  localparam logic [2:0]  ST_SETUP        = 3'd1;
  localparam logic [2:0]  ST_PULSE        = 3'd2;
  localparam logic [2:0]  ST_WAIT_DROP    = 3'd3;
  localparam logic [2:0]  ST_WAIT_RISE    = 3'd4;
  localparam logic [2:0]  ST_DONE         = 3'd5;
  localparam logic [2:0]  ST_ERROR        = 3'd6;

  // Arm position after one step, clamped to the 0..MAX_CYL range.
  function automatic logic [7:0] next_position(input logic [7:0] cur,
                                               input logic       fwd,
                                               input logic       two);
    logic [8:0] size;
    logic [8:0] sum;
    logic [7:0] result;
    size = two ? STEP_TWO_CYL : STEP_ONE_CYL;
    if (fwd) begin
      sum    = {1'b0, cur} + size;
      result = (sum > {1'b0, MAX_CYL}) ? MAX_CYL : sum[7:0];
    end else if ({1'b0, cur} < size) begin
      result = 8'd0;
    end else begin
      sum    = {1'b0, cur} - size;
      result = sum[7:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/seek_command_generator_bus_input_sync.sv
// Three-flop synchronizer for an asynchronous drive status line, plus a
// one-clock change flag derived from the synchronized copy.
module seek_command_generator_bus_input_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset_l,
  input  logic async_in,
  output logic level,
  output logic changed
);

  logic [2:0] sync_ff;
  logic       prev;

  // Shift the raw line through three flops and remember the last synced value.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      sync_ff <= {3{RESET_VAL}};
      prev    <= RESET_VAL;
    end else begin
      sync_ff <= {sync_ff[1:0], async_in};
      prev    <= sync_ff[2];
    end
  end

  assign level   = sync_ff[2];
  assign changed = sync_ff[2] ^ prev;

endmodule

// File: rtl/seek_command_generator.sv
// Controller-side 2310 seek initiator. Breaks an absolute cylinder target
// into 1- and 2-cylinder ACC_GO steps, paces each step on the drive's
// ACCESS_RDY handshake, tracks the arm position and recalibrates to home.
//
// Handshake: a step is SETUP (REV/10_20 settle), PULSE (GO low),
// WAIT_DROP (ready must fall), WAIT_RISE (ready returns high = step done).
// Requests are single-clock strobes honoured only in IDLE.
module seek_command_generator
  import seek_command_generator_pkg::*;
(
  input  logic       clock,
  input  logic       reset_l,
  input  logic       clkenbl_1usec,
  input  logic       seek_request,
  input  logic       recal_request,
  input  logic [7:0] target_cylinder,
  input  logic       BUS_ACCESS_RDY_H,
  input  logic       BUS_HOME_L,
  output logic       BUS_ACC_GO_L,
  output logic       BUS_ACC_REV_L,
  output logic       BUS_10_20_L,
  output logic [7:0] current_cylinder,
  output logic       seek_busy,
  output logic       seek_done,
  output logic       seek_error
);

  logic [2:0]        state;
  logic [15:0]       timer;
  logic [7:0]        target_cyl;
  logic              recal_mode;
  logic [6:0]        step_count;
  logic              drop_seen;
  logic              home_seen;

  logic              ready_level;
  logic              ready_changed;
  logic              home_level;
  logic              home_changed;
  logic              ready_fall;
  logic              ready_rise;
  logic              home_fall;
  logic              home_now;

  logic signed [8:0] delta;
  logic              delta_big;
  logic              step_fwd;
  logic              step_two;
  logic [7:0]        stepped_pos;
  logic [7:0]        landed_pos;
  logic [6:0]        next_count;

  seek_command_generator_bus_input_sync #(.RESET_VAL(1'b1)) u_ready_sync (
    .clock    (clock),
    .reset_l  (reset_l),
    .async_in (BUS_ACCESS_RDY_H),
    .level    (ready_level),
    .changed  (ready_changed)
  );

  seek_command_generator_bus_input_sync #(.RESET_VAL(1'b1)) u_home_sync (
    .clock    (clock),
    .reset_l  (reset_l),
    .async_in (BUS_HOME_L),
    .level    (home_level),
    .changed  (home_changed)
  );

  assign ready_fall  = ready_changed & ~ready_level;
  assign ready_rise  = ready_changed &  ready_level;
  assign home_fall   = home_changed  & ~home_level;
  // A brief home pulse during the step still counts at step completion.
  assign home_now    = ~home_level | home_seen;

  assign delta       = $signed({1'b0, target_cyl}) - $signed({1'b0, current_cylinder});
  assign delta_big   = (delta >= 9'sd2) || (delta <= -9'sd2);

  assign step_fwd    = (BUS_ACC_REV_L == REV_FWD);
  assign step_two    = (BUS_10_20_L == STEP_TWO);
  assign stepped_pos = next_position(current_cylinder, step_fwd, step_two);
  assign landed_pos  = home_now ? 8'd0 : stepped_pos;
  assign next_count  = step_count + 7'd1;

  // Sequencer, usec timer and arm-position tracker.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state            <= ST_IDLE;
      timer            <= '0;
      BUS_ACC_GO_L     <= GO_IDLE;
      BUS_ACC_REV_L    <= REV_FWD;
      BUS_10_20_L      <= STEP_TWO;
      current_cylinder <= '0;
      target_cyl       <= '0;
      seek_busy        <= 1'b0;
      seek_done        <= 1'b0;
      seek_error       <= 1'b0;
      recal_mode       <= 1'b0;
      step_count       <= '0;
      drop_seen        <= 1'b0;
      home_seen        <= 1'b0;
    end else begin
      // Free-running usec count; every state change below clears it.
      if (clkenbl_1usec && (timer != 16'hFFFF)) timer <= timer + 16'd1;
      seek_done <= 1'b0;

      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (recal_request) begin
            seek_error <= 1'b0;
            recal_mode <= 1'b1;
            step_count <= '0;
            if (!home_level) begin
              current_cylinder <= '0;
              seek_busy        <= 1'b0;
              seek_done        <= 1'b1;
              state            <= ST_DONE;
            end else begin
              seek_busy <= 1'b1;
              state     <= ST_SETUP;
            end
          end else if (seek_request) begin
            if (target_cylinder > MAX_CYL) begin
              seek_error <= 1'b1;
            end else if (target_cylinder == current_cylinder) begin
              seek_error <= 1'b0;
              seek_done  <= 1'b1;
              state      <= ST_DONE;
            end else begin
              seek_error <= 1'b0;
              seek_busy  <= 1'b1;
              recal_mode <= 1'b0;
              target_cyl <= target_cylinder;
              state      <= ST_SETUP;
            end
          end
        end

        ST_SETUP: begin
          drop_seen <= 1'b0;
          home_seen <= 1'b0;
          if (recal_mode) begin
            BUS_ACC_REV_L <= REV_REV;
            BUS_10_20_L   <= STEP_TWO;
          end else begin
            BUS_ACC_REV_L <= (delta > 9'sd0) ? REV_FWD : REV_REV;
            BUS_10_20_L   <= delta_big ? STEP_TWO : STEP_ONE;
          end
          if (timer >= SETUP_US) begin
            BUS_ACC_GO_L <= GO_ASSERT;
            timer        <= '0;
            state        <= ST_PULSE;
          end
        end

        ST_PULSE: begin
          // The drive may drop ready while GO is still low; remember it.
          if (ready_fall) drop_seen <= 1'b1;
          if (home_fall)  home_seen <= 1'b1;
          if (timer >= GO_PULSE_US) begin
            BUS_ACC_GO_L <= GO_IDLE;
            timer        <= '0;
            state        <= ST_WAIT_DROP;
          end
        end

        ST_WAIT_DROP: begin
          if (home_fall) home_seen <= 1'b1;
          if (drop_seen || ready_fall) begin
            timer <= '0;
            state <= ST_WAIT_RISE;
          end else if (timer >= DROP_TIMEOUT_US) begin
            seek_error    <= 1'b1;
            seek_busy     <= 1'b0;
            BUS_ACC_GO_L  <= GO_IDLE;
            BUS_ACC_REV_L <= REV_FWD;
            BUS_10_20_L   <= STEP_TWO;
            timer         <= '0;
            state         <= ST_ERROR;
          end
        end

        ST_WAIT_RISE: begin
          if (home_fall) home_seen <= 1'b1;
          if (ready_rise) begin
            current_cylinder <= landed_pos;
            step_count       <= next_count;
            timer            <= '0;
            if (recal_mode ? home_now : (landed_pos == target_cyl)) begin
              seek_busy     <= 1'b0;
              seek_done     <= 1'b1;
              BUS_ACC_REV_L <= REV_FWD;
              BUS_10_20_L   <= STEP_TWO;
              state         <= ST_DONE;
            end else if (recal_mode && (next_count == MAX_RECAL_STEPS)) begin
              seek_error    <= 1'b1;
              seek_busy     <= 1'b0;
              BUS_ACC_REV_L <= REV_FWD;
              BUS_10_20_L   <= STEP_TWO;
              state         <= ST_ERROR;
            end else begin
              state <= ST_SETUP;
            end
          end else if (timer >= RISE_TIMEOUT_US) begin
            seek_error    <= 1'b1;
            seek_busy     <= 1'b0;
            BUS_ACC_GO_L  <= GO_IDLE;
            BUS_ACC_REV_L <= REV_FWD;
            BUS_10_20_L   <= STEP_TWO;
            timer         <= '0;
            state         <= ST_ERROR;
          end
        end

        ST_DONE: begin
          timer <= '0;
          state <= ST_IDLE;
        end

        ST_ERROR: begin
          BUS_ACC_GO_L <= GO_IDLE;
          timer        <= '0;
          state        <= ST_IDLE;
        end

        default: begin
          BUS_ACC_GO_L <= GO_IDLE;
          seek_busy    <= 1'b0;
          timer        <= '0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seek_command_generator.sv
// Directed bench for seek_command_generator with a scripted 2310 drive model
// that answers each GO pulse with a ready drop/rise and tracks its own arm.
module tb_seek_command_generator;

  logic       clock = 1'b0;
  logic       reset_l;
  logic       clkenbl_1usec;
  logic       seek_request;
  logic       recal_request;
  logic [7:0] target_cylinder;
  logic       BUS_ACCESS_RDY_H;
  logic       BUS_HOME_L;
  logic       BUS_ACC_GO_L;
  logic       BUS_ACC_REV_L;
  logic       BUS_10_20_L;
  logic [7:0] current_cylinder;
  logic       seek_busy;
  logic       seek_done;
  logic       seek_error;

  int         tests_run;
  int         failed;
  int         done_cnt;
  int         pulse_en;
  int         min_pulse;
  int         model_cyl;
  bit         model_drop;
  logic       go_prev;
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];

  seek_command_generator dut (
    .clock            (clock),
    .reset_l          (reset_l),
    .clkenbl_1usec    (clkenbl_1usec),
    .seek_request     (seek_request),
    .recal_request    (recal_request),
    .target_cylinder  (target_cylinder),
    .BUS_ACCESS_RDY_H (BUS_ACCESS_RDY_H),
    .BUS_HOME_L       (BUS_HOME_L),
    .BUS_ACC_GO_L     (BUS_ACC_GO_L),
    .BUS_ACC_REV_L    (BUS_ACC_REV_L),
    .BUS_10_20_L      (BUS_10_20_L),
    .current_cylinder (current_cylinder),
    .seek_busy        (seek_busy),
    .seek_done        (seek_done),
    .seek_error       (seek_error)
  );

  // ---------------- clock / reset / usec enable ----------------
  always #10 clock = ~clock;

  initial begin
    #1_900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Monitor + usec enable generator (enable high every other clock).
  // Logs each GO step as a signed size (+ forward, - reverse) and counts
  // usec ticks seen while GO was low.
  always @(negedge clock) begin
    if (seek_done === 1'b1) done_cnt++;
    if (go_prev === 1'b0 && clkenbl_1usec === 1'b1) pulse_en++;
    if (go_prev === 1'b1 && BUS_ACC_GO_L === 1'b0) begin
      if (BUS_ACC_REV_L === 1'b1) obs_q.push_back(BUS_10_20_L ? 8'd2 : 8'd1);
      else                        obs_q.push_back(BUS_10_20_L ? 8'hFE : 8'hFF);
      pulse_en = 0;
    end
    if (go_prev === 1'b0 && BUS_ACC_GO_L === 1'b1) begin
      if (pulse_en < min_pulse) min_pulse = pulse_en;
    end
    go_prev       = BUS_ACC_GO_L;
    clkenbl_1usec = ~clkenbl_1usec;
  end

  // Scripted drive: ready drops shortly after GO, the arm moves, home is
  // updated, then ready returns high. With model_drop clear it ignores GO.
  always begin : drive_model
    logic st_rev;
    int   step;
    @(negedge BUS_ACC_GO_L);
    st_rev = BUS_ACC_REV_L;
    step   = BUS_10_20_L ? 2 : 1;
    if (model_drop) begin
      repeat (2) @(negedge clock);
      BUS_ACCESS_RDY_H = 1'b0;
      repeat (16) @(negedge clock);
      if (st_rev) model_cyl = (model_cyl + step > 202) ? 202 : model_cyl + step;
      else        model_cyl = (model_cyl < step) ? 0 : model_cyl - step;
      BUS_HOME_L = (model_cyl == 0) ? 1'b0 : 1'b1;
      repeat (4) @(negedge clock);
      BUS_ACCESS_RDY_H = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_capture();
    obs_q.delete();
    exp_q.delete();
    done_cnt  = 0;
    min_pulse = 1000;
  endtask

  task automatic issue_seek(input logic [7:0] tgt);
    target_cylinder = tgt;
    seek_request    = 1'b1;
    @(negedge clock);
    seek_request    = 1'b0;
  endtask

  task automatic issue_recal();
    recal_request = 1'b1;
    @(negedge clock);
    recal_request = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output logic timed_out);
    int n;
    n = 0;
    timed_out = 1'b0;
    while (seek_busy === 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (seek_busy === 1'b1) timed_out = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    tests_run++;
    if (BUS_ACC_GO_L !== 1'b1) begin failed++; $display("FAIL reset_go: got %b want 1", BUS_ACC_GO_L); end
    tests_run++;
    if (BUS_ACC_REV_L !== 1'b1) begin failed++; $display("FAIL reset_rev: got %b want 1", BUS_ACC_REV_L); end
    tests_run++;
    if (BUS_10_20_L !== 1'b1) begin failed++; $display("FAIL reset_10_20: got %b want 1", BUS_10_20_L); end
    tests_run++;
    if (current_cylinder !== 8'd0) begin failed++; $display("FAIL reset_cyl: got %0d want 0", current_cylinder); end
    tests_run++;
    if ({seek_busy, seek_done, seek_error} !== 3'b000) begin
      failed++; $display("FAIL reset_status: got busy/done/err %b want 000", {seek_busy, seek_done, seek_error});
    end
    reset_l = 1'b1;
    repeat (6) @(negedge clock);
    tests_run++;
    if (seek_busy !== 1'b0 || BUS_ACC_GO_L !== 1'b1) begin
      failed++; $display("FAIL post_reset_idle: got busy %b go %b want 0 1", seek_busy, BUS_ACC_GO_L);
    end
  endtask

  task automatic test_seek_forward();
    logic to;
    start_capture();
    exp_q = '{8'd2, 8'd2, 8'd2, 8'd1};
    issue_seek(8'd7);
    tests_run++;
    if (seek_busy !== 1'b1) begin failed++; $display("FAIL fwd_busy: got %b want 1", seek_busy); end
    wait_idle(2000, to);
    tests_run++;
    if (to) begin failed++; $display("FAIL fwd_timeout: busy still %b want 0", seek_busy); end
    tests_run++;
    if (current_cylinder !== 8'd7) begin failed++; $display("FAIL fwd_cyl: got %0d want 7", current_cylinder); end
    tests_run++;
    if (done_cnt != 1) begin failed++; $display("FAIL fwd_done_count: got %0d want 1", done_cnt); end
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      failed++; $display("FAIL fwd_steps: got %0d steps want %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i])
        if (obs_q[i] !== exp_q[i]) begin
          failed++; $display("FAIL fwd_steps: step %0d got %0d want %0d", i, $signed(obs_q[i]), $signed(exp_q[i]));
          break;
        end
    end
    tests_run++;
    if (min_pulse < 4) begin failed++; $display("FAIL fwd_go_width: got %0d usec want >=4", min_pulse); end
    tests_run++;
    if (model_cyl != 7) begin failed++; $display("FAIL fwd_drive_cyl: got %0d want 7", model_cyl); end
  endtask

  task automatic test_seek_same();
    start_capture();
    issue_seek(8'd7);
    tests_run++;
    if (seek_done !== 1'b1 || seek_busy !== 1'b0) begin
      failed++; $display("FAIL same_done: got done %b busy %b want 1 0", seek_done, seek_busy);
    end
    repeat (20) @(negedge clock);
    tests_run++;
    if (done_cnt != 1 || obs_q.size() != 0) begin
      failed++; $display("FAIL same_no_step: got done %0d steps %0d want 1 0", done_cnt, obs_q.size());
    end
  endtask

  task automatic test_bad_target();
    logic to;
    logic busy_seen;
    start_capture();
    busy_seen = 1'b0;
    issue_seek(8'd203);
    tests_run++;
    if (seek_error !== 1'b1 || seek_busy !== 1'b0) begin
      failed++; $display("FAIL bad_error: got err %b busy %b want 1 0", seek_error, seek_busy);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (seek_busy !== 1'b0) busy_seen = 1'b1;
    end
    tests_run++;
    if (busy_seen || obs_q.size() != 0 || seek_error !== 1'b1) begin
      failed++; $display("FAIL bad_quiet: got busy_seen %b steps %0d err %b want 0 0 1", busy_seen, obs_q.size(), seek_error);
    end
    // Next valid request (7 -> 9) clears the sticky error.
    issue_seek(8'd9);
    tests_run++;
    if (seek_error !== 1'b0 || seek_busy !== 1'b1) begin
      failed++; $display("FAIL bad_clear: got err %b busy %b want 0 1", seek_error, seek_busy);
    end
    wait_idle(2000, to);
    tests_run++;
    if (to || current_cylinder !== 8'd9) begin
      failed++; $display("FAIL seek_to_9: got cyl %0d timeout %b want 9 0", current_cylinder, to);
    end
  endtask

  task automatic test_recal();
    logic to;
    start_capture();
    for (int i = 0; i < 5; i++) exp_q.push_back(8'hFE);
    issue_recal();
    tests_run++;
    if (seek_busy !== 1'b1) begin failed++; $display("FAIL recal_busy: got %b want 1", seek_busy); end
    wait_idle(2000, to);
    tests_run++;
    if (to || current_cylinder !== 8'd0 || done_cnt != 1) begin
      failed++; $display("FAIL recal_end: got cyl %0d done %0d timeout %b want 0 1 0", current_cylinder, done_cnt, to);
    end
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      failed++; $display("FAIL recal_steps: got %0d steps want %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i])
        if (obs_q[i] !== exp_q[i]) begin
          failed++; $display("FAIL recal_steps: step %0d got %0d want %0d", i, $signed(obs_q[i]), $signed(exp_q[i]));
          break;
        end
    end
  endtask

  task automatic test_recal_at_home();
    start_capture();
    issue_recal();
    tests_run++;
    if (seek_done !== 1'b1 || seek_busy !== 1'b0) begin
      failed++; $display("FAIL home_recal_done: got done %b busy %b want 1 0", seek_done, seek_busy);
    end
    repeat (20) @(negedge clock);
    tests_run++;
    if (obs_q.size() != 0 || current_cylinder !== 8'd0) begin
      failed++; $display("FAIL home_recal_quiet: got steps %0d cyl %0d want 0 0", obs_q.size(), current_cylinder);
    end
  endtask

  task automatic test_seek_reverse();
    logic to;
    issue_seek(8'd100);
    wait_idle(6000, to);
    tests_run++;
    if (to || current_cylinder !== 8'd100) begin
      failed++; $display("FAIL seek_to_100: got cyl %0d timeout %b want 100 0", current_cylinder, to);
    end
    start_capture();
    exp_q = '{8'hFE, 8'hFF};
    issue_seek(8'd97);
    wait_idle(2000, to);
    tests_run++;
    if (to || current_cylinder !== 8'd97 || model_cyl != 97) begin
      failed++; $display("FAIL rev_cyl: got cyl %0d drive %0d want 97 97", current_cylinder, model_cyl);
    end
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      failed++; $display("FAIL rev_steps: got %0d steps want %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i])
        if (obs_q[i] !== exp_q[i]) begin
          failed++; $display("FAIL rev_steps: step %0d got %0d want %0d", i, $signed(obs_q[i]), $signed(exp_q[i]));
          break;
        end
    end
  endtask

  task automatic test_max_boundary();
    logic to;
    start_capture();
    issue_seek(8'd202);
    tests_run++;
    if (seek_busy !== 1'b1 || seek_error !== 1'b0) begin
      failed++; $display("FAIL max_accept: got busy %b err %b want 1 0", seek_busy, seek_error);
    end
    wait_idle(6000, to);
    tests_run++;
    if (to || current_cylinder !== 8'd202 || model_cyl != 202 || obs_q.size() != 53) begin
      failed++; $display("FAIL max_seek: got cyl %0d drive %0d steps %0d want 202 202 53",
                         current_cylinder, model_cyl, obs_q.size());
    end
    issue_seek(8'd50);
    wait_idle(6000, to);
    tests_run++;
    if (to || current_cylinder !== 8'd50 || model_cyl != 50) begin
      failed++; $display("FAIL seek_to_50: got cyl %0d drive %0d want 50 50", current_cylinder, model_cyl);
    end
  endtask

  task automatic test_simultaneous();
    logic to;
    start_capture();
    for (int i = 0; i < 25; i++) exp_q.push_back(8'hFE);
    target_cylinder = 8'd60;
    seek_request    = 1'b1;
    recal_request   = 1'b1;
    @(negedge clock);
    seek_request    = 1'b0;
    recal_request   = 1'b0;
    wait_idle(4000, to);
    tests_run++;
    if (to || current_cylinder !== 8'd0 || model_cyl != 0 || done_cnt != 1) begin
      failed++; $display("FAIL simul_end: got cyl %0d drive %0d done %0d want 0 0 1",
                         current_cylinder, model_cyl, done_cnt);
    end
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      failed++; $display("FAIL simul_steps: got %0d steps want %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i])
        if (obs_q[i] !== exp_q[i]) begin
          failed++; $display("FAIL simul_steps: step %0d got %0d want %0d", i, $signed(obs_q[i]), $signed(exp_q[i]));
          break;
        end
    end
  endtask

  task automatic test_drop_timeout();
    logic to;
    start_capture();
    model_drop = 1'b0;
    issue_seek(8'd10);
    repeat (15000) @(negedge clock);
    tests_run++;
    if (seek_error !== 1'b0 || seek_busy !== 1'b1) begin
      failed++; $display("FAIL timeout_early: got err %b busy %b want 0 1", seek_error, seek_busy);
    end
    wait_idle(10000, to);
    tests_run++;
    if (to || seek_error !== 1'b1 || BUS_ACC_GO_L !== 1'b1) begin
      failed++; $display("FAIL timeout_error: got err %b go %b timeout %b want 1 1 0", seek_error, BUS_ACC_GO_L, to);
    end
    tests_run++;
    if (current_cylinder !== 8'd0 || done_cnt != 0 || obs_q.size() != 1) begin
      failed++; $display("FAIL timeout_state: got cyl %0d done %0d steps %0d want 0 0 1",
                         current_cylinder, done_cnt, obs_q.size());
    end
    model_drop = 1'b1;
  endtask

  task automatic test_reset_mid_pulse();
    logic to;
    int   n;
    issue_seek(8'd3);
    wait_idle(2000, to);
    tests_run++;
    if (to || current_cylinder !== 8'd3 || seek_error !== 1'b0) begin
      failed++; $display("FAIL seek_to_3: got cyl %0d err %b want 3 0", current_cylinder, seek_error);
    end
    model_drop = 1'b0;
    issue_seek(8'd6);
    n = 0;
    while (BUS_ACC_GO_L !== 1'b0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    tests_run++;
    if (BUS_ACC_GO_L !== 1'b0) begin failed++; $display("FAIL pulse_reach: got go %b want 0", BUS_ACC_GO_L); end
    #2;
    reset_l = 1'b0;
    #1;
    tests_run++;
    if (BUS_ACC_GO_L !== 1'b1 || current_cylinder !== 8'd0 || seek_busy !== 1'b0) begin
      failed++; $display("FAIL async_reset: got go %b cyl %0d busy %b want 1 0 0",
                         BUS_ACC_GO_L, current_cylinder, seek_busy);
    end
    @(negedge clock);
    reset_l = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    tests_run        = 0;
    failed           = 0;
    done_cnt         = 0;
    pulse_en         = 0;
    min_pulse        = 1000;
    model_cyl        = 0;
    model_drop       = 1'b1;
    go_prev          = 1'b1;
    clkenbl_1usec    = 1'b0;
    seek_request     = 1'b0;
    recal_request    = 1'b0;
    target_cylinder  = 8'd0;
    BUS_ACCESS_RDY_H = 1'b1;
    BUS_HOME_L       = 1'b0;
    reset_l          = 1'b1;
    #1 reset_l       = 1'b0;
    repeat (5) @(negedge clock);

    test_reset();
    test_seek_forward();
    test_seek_same();
    test_bad_target();
    test_recal();
    test_recal_at_home();
    test_seek_reverse();
    test_max_boundary();
    test_simultaneous();
    test_drop_timeout();
    test_reset_mid_pulse();

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
